keypad_sequencer: RTL

KEYPAD_SEQUENCER -- requirements
Module: keypad_sequencer

---
 rtl/keypad_seq_pkg.sv | 23 ++
 rtl/keypad_sequencer_digit_to_key.sv | 16 +
 rtl/keypad_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/keypad_seq_pkg.sv
// Shared types and constants for the calculator keypad sequencer.
package keypad_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_GAP0,
    ST_KEYX,
    ST_GAPX,
    ST_KEYY,
    ST_GAPY,
    ST_EQ,
    ST_DONE
  } state_e;

  localparam logic [9:0] KEY_IDLE  = 10'h3FF;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/keypad_sequencer_digit_to_key.sv
// BCD digit to active-low one-hot key lines; non-decimal codes press nothing.
module digit_to_key
  import keypad_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [9:0] key_o
);

  always_comb begin
    key_o = KEY_IDLE;
    if (digit_ok(digit_i)) begin
      key_o = ~(10'd1 << digit_i);
    end
  end

endmodule

// File: rtl/keypad_sequencer.sv
// Drives a calculator keypad through clear, X, Y and EQUAL presses for one
// BCD add/subtract request; every output comes straight from a flop.
module keypad_sequencer
  import keypad_seq_pkg::*;
#(
  parameter int unsigned START_CYC = 2,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic       CLK,
  input  logic       CLRb,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [3:0] i_X,
  input  logic [3:0] i_Y,
  input  logic       i_sub,
  output logic [9:0] o_A,
  output logic       o_START,
  output logic       o_EQUAL,
  output logic       o_Addn_Sub,
  output logic       o_done,
  output logic       o_err
);

  // Counter load values: a state with load L lasts L+1 cycles.
  localparam logic [7:0] START_LD = 8'(START_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic [9:0] a_q, a_d;
  logic       start_q, start_d;
  logic       eq_q, eq_d;
  logic       as_q, as_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;

  logic       accept;
  logic       cnt_zero;
  logic [3:0] key_digit;
  logic [9:0] key_lines;

  assign accept   = (state_q == ST_IDLE) && i_valid && ready_q;
  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? 8'd0 : cnt_q - 8'd1;
    x_d     = x_q;
    y_d     = y_q;
    as_d    = as_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (digit_ok(i_X) && digit_ok(i_Y)) begin
            state_d = ST_CLR;
            cnt_d   = START_LD;
            x_d     = i_X;
            y_d     = i_Y;
            as_d    = i_sub;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLR:  if (cnt_zero) begin state_d = ST_GAP0; cnt_d = GAP_LD;  end
      ST_GAP0: if (cnt_zero) begin state_d = ST_KEYX; cnt_d = HOLD_LD; end
      ST_KEYX: if (cnt_zero) begin state_d = ST_GAPX; cnt_d = GAP_LD;  end
      ST_GAPX: if (cnt_zero) begin state_d = ST_KEYY; cnt_d = HOLD_LD; end
      ST_KEYY: if (cnt_zero) begin state_d = ST_GAPY; cnt_d = GAP_LD;  end
      ST_GAPY: if (cnt_zero) begin state_d = ST_EQ;   cnt_d = HOLD_LD; end
      ST_EQ:   if (cnt_zero) begin state_d = ST_DONE; cnt_d = 8'd0;    end
      ST_DONE: begin state_d = ST_IDLE; cnt_d = 8'd0; end
      default: begin state_d = ST_IDLE; cnt_d = 8'd0; end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  assign key_digit = (state_d == ST_KEYY) ? y_q : x_q;

  digit_to_key u_digit_to_key (
    .digit_i (key_digit),
    .key_o   (key_lines)
  );

  always_comb begin
    a_d     = ((state_d == ST_KEYX) || (state_d == ST_KEYY)) ? key_lines : KEY_IDLE;
    start_d = (state_d != ST_CLR);
    eq_d    = (state_d == ST_EQ);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      a_q     <= KEY_IDLE;
      start_q <= 1'b0;
      eq_q    <= 1'b0;
      as_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      a_q     <= a_d;
      start_q <= start_d;
      eq_q    <= eq_d;
      as_q    <= as_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign o_A        = a_q;
  assign o_START    = start_q;
  assign o_EQUAL    = eq_q;
  assign o_Addn_Sub = as_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_ready    = ready_q;

endmodule
